// File: rtl/even_p_pkg.sv
// Shared types and framing constants for the 3-bit even-parity serial link.
// The frame is start, three data bits LSB first, parity, stop.
package even_p_pkg;

  localparam int   DATA_W     = 3;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam int   FRAME_BITS = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Bit-period counter width; a single-cycle bit still needs a 1-bit counter.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/even_p_gen_3bit.sv
// Combinational even-parity generator: p makes the 4-bit total {i, p} even.
// Zero latency, no flow control.
module even_p_gen_3bit
  import even_p_pkg::*;
(
  input  logic [DATA_W-1:0] i,
  output logic              p
);

  assign p = ^i;

endmodule

// File: rtl/even_p_serial_tx.sv
// Even-parity serial transmitter: one word per frame, first frame bit appears the cycle after acceptance.
// din_ready is low for the whole 6*CLKS_PER_BIT frame; EVEN_P_TX_INJECT_EN adds par_flip for parity error injection.
module even_p_serial_tx
  import even_p_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef EVEN_P_TX_INJECT_EN
  input  logic              par_flip,
`endif
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              p_out
);

  localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       LAST_BIT = 2'(DATA_W - 1);

  tx_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        bit_idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic              tx_q;
  logic              din_ready_q;
  logic              busy_q;
  logic              p_out_q;
  logic              p_gen;
  logic              p_acc;
  logic              bit_done;

  even_p_gen_3bit u_gen (
    .i (din),
    .p (p_gen)
  );

`ifdef EVEN_P_TX_INJECT_EN
  assign p_acc = p_gen ^ par_flip;
`else
  assign p_acc = p_gen;
`endif

  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (bit_done) begin
      cnt_d = '0;
    end
  end

  // Each transition loads tx_q with the level of the state being entered,
  // so the line changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= STOP_LVL;
      din_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      p_out_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= STOP_LVL;
          if (din_valid && din_ready_q) begin
            shreg_q     <= din;
            p_out_q     <= p_acc;
            bit_idx_q   <= '0;
            state_q     <= START;
            tx_q        <= START_LVL;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + 2'd1;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= PARITY;
              tx_q    <= p_out_q;
            end else begin
              tx_q    <= shreg_q[1];
            end
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= STOP_LVL;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (bit_done) begin
            state_q     <= IDLE;
            tx_q        <= STOP_LVL;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          tx_q        <= STOP_LVL;
          din_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign p_out     = p_out_q;

endmodule

// File: tb/tb_even_p_serial_tx.sv
// Bench for even_p_serial_tx: two instances (4 and 1 clocks per bit) checked against a frame-level model.
// Define EVEN_P_TX_INJECT_EN to also exercise parity error injection.
module tb_even_p_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din;
  logic       vld4, vld1;
  logic       rdy4, tx4, busy4, p4;
  logic       rdy1, tx1, busy1, p1;
`ifdef EVEN_P_TX_INJECT_EN
  logic       par_flip;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  even_p_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (vld4),
`ifdef EVEN_P_TX_INJECT_EN
    .par_flip  (par_flip),
`endif
    .din_ready (rdy4),
    .tx        (tx4),
    .busy      (busy4),
    .p_out     (p4)
  );

  even_p_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (vld1),
`ifdef EVEN_P_TX_INJECT_EN
    .par_flip  (par_flip),
`endif
    .din_ready (rdy1),
    .tx        (tx1),
    .busy      (busy1),
    .p_out     (p1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame model: parity from the population count, bits by position in the frame.
  function automatic logic ref_parity(input logic [2:0] d, input logic pf);
    return logic'(($countones(d) + int'(pf)) % 2);
  endfunction

  function automatic logic ref_bit(input logic [2:0] d, input logic pf, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 3) return logic'((int'(d) >> (idx - 1)) % 2);
    if (idx == 4) return ref_parity(d, pf);
    return 1'b1;
  endfunction

  function automatic logic get_tx(input int n);   return (n == 1) ? tx1 : tx4;     endfunction
  function automatic logic get_rdy(input int n);  return (n == 1) ? rdy1 : rdy4;   endfunction
  function automatic logic get_busy(input int n); return (n == 1) ? busy1 : busy4; endfunction
  function automatic logic get_p(input int n);    return (n == 1) ? p1 : p4;       endfunction

  // Called #1 after an edge with din/valid already set; the next edge accepts.
  task automatic run_frame(input int n, input logic [2:0] d, input logic pf, input logic hold,
                           input logic [2:0] d_mid, output int start_cyc);
    logic [2:0] rec_i;
    logic       rec_p;
    rec_i = '0;
    rec_p = 1'b0;
    @(posedge clk); #1;
    start_cyc = cyc;
    if (!hold) begin
      vld4 = 1'b0;
      vld1 = 1'b0;
    end
    chk($sformatf("p_out n%0d d%0d", n, d), 8'(get_p(n)), 8'(ref_parity(d, pf)));
    for (int idx = 0; idx < 6; idx++) begin
      for (int c = 0; c < n; c++) begin
        if (idx == 1 && c == 0) din = d_mid;
        chk($sformatf("tx n%0d d%0d bit%0d c%0d", n, d, idx, c), 8'(get_tx(n)), 8'(ref_bit(d, pf, idx)));
        chk($sformatf("busy n%0d bit%0d", n, idx), 8'(get_busy(n)), 8'd1);
        chk($sformatf("din_ready n%0d bit%0d", n, idx), 8'(get_rdy(n)), 8'd0);
        if (c == n / 2) begin
          if (idx >= 1 && idx <= 3) rec_i[idx-1] = get_tx(n);
          if (idx == 4) rec_p = get_tx(n);
        end
        @(posedge clk); #1;
      end
    end
    chk($sformatf("ready after frame n%0d", n), 8'(get_rdy(n)), 8'd1);
    chk($sformatf("busy after frame n%0d", n), 8'(get_busy(n)), 8'd0);
    chk($sformatf("tx idle after frame n%0d", n), 8'(get_tx(n)), 8'd1);
    chk($sformatf("recovered i n%0d", n), 8'(rec_i), 8'(d));
    chk($sformatf("checker pc n%0d d%0d", n, d), 8'(^{rec_i, rec_p}), 8'(pf));
  endtask

  initial begin
    int s1, s2, n, gap;
    logic [2:0] w;

    rst  = 1'b1;
    din  = '0;
    vld4 = 1'b0;
    vld1 = 1'b0;
`ifdef EVEN_P_TX_INJECT_EN
    par_flip = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk("reset tx4", 8'(tx4), 8'd1);
    chk("reset rdy4", 8'(rdy4), 8'd1);
    chk("reset busy4", 8'(busy4), 8'd0);
    chk("reset p4", 8'(p4), 8'd0);
    chk("reset tx1", 8'(tx1), 8'd1);
    chk("reset rdy1", 8'(rdy1), 8'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single 3'b101 frame at N=4.
    din = 3'b101; vld4 = 1'b1;
    run_frame(4, 3'b101, 1'b0, 1'b0, 3'($urandom), s1);

    // Reset during the start bit: line returns high before the next edge.
    din = 3'b111; vld4 = 1'b1;
    @(posedge clk); #1;
    vld4 = 1'b0;
    @(posedge clk); #1;
    chk("start bit before abort", 8'(tx4), 8'd0);
    #3 rst = 1'b1;
    #1;
    chk("async abort tx", 8'(tx4), 8'd1);
    chk("async abort rdy", 8'(rdy4), 8'd1);
    chk("async abort busy", 8'(busy4), 8'd0);
    chk("async abort p_out", 8'(p4), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("no resume after abort", 8'(tx4), 8'd1);
      @(posedge clk); #1;
    end

    // Parity sweep over every word at N=1.
    for (int v = 0; v < 8; v++) begin
      din = 3'(v); vld1 = 1'b1;
      run_frame(1, 3'(v), 1'b0, 1'b0, 3'($urandom), s1);
    end

    // Back-to-back at N=4 with valid held; din changes mid-frame.
    din = 3'b011; vld4 = 1'b1;
    run_frame(4, 3'b011, 1'b0, 1'b1, 3'b100, s1);
    run_frame(4, 3'b100, 1'b0, 1'b0, 3'($urandom), s2);
    chk("b2b start spacing n4", 8'(s2 - s1), 8'd25);

    // Back-to-back at N=1.
    din = 3'b110; vld1 = 1'b1;
    run_frame(1, 3'b110, 1'b0, 1'b1, 3'b110, s1);
    run_frame(1, 3'b110, 1'b0, 1'b0, 3'($urandom), s2);
    chk("b2b start spacing n1", 8'(s2 - s1), 8'd7);

    // Random words, instance and idle gaps.
    for (int r = 0; r < 10; r++) begin
      n   = ($urandom_range(0, 1) == 0) ? 1 : 4;
      w   = 3'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      din = w;
      if (n == 1) vld1 = 1'b1; else vld4 = 1'b1;
      run_frame(n, w, 1'b0, 1'b0, 3'($urandom), s1);
    end

`ifdef EVEN_P_TX_INJECT_EN
    par_flip = 1'b1;
    din = 3'b101; vld4 = 1'b1;
    run_frame(4, 3'b101, 1'b1, 1'b0, 3'($urandom), s1);
    par_flip = 1'b0;
    din = 3'b101; vld4 = 1'b1;
    run_frame(4, 3'b101, 1'b0, 1'b0, 3'($urandom), s1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
